ssd_driver: RTL and testbench



---
 rtl/ssd_driver.sv | 131 +++++++++++++
 tb/tb_ssd_driver.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ssd_driver.sv
// rtl/ssd_driver.sv - 4-digit multiplexed common-anode seven-segment driver with anti-ghost blanking
// Optional leading-zero suppression in char mode: define SSD_LEADING_ZERO_BLANK_EN.
module ssd_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ssd_bits,
    input  logic        ssd_char_mode,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int          PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    digit;
    logic          in_blank;
    logic          suppress;
    logic [7:0]    cur_byte;
    logic [7:0]    seg_d;
    logic [3:0]    an_d;

    // Active-low glyph for a hex nibble, bit order g..a.
    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        logic [6:0] g;
        case (h)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] char_glyph(input logic [6:0] c);
        logic [6:0] g;
        g = 7'h7F;
        if (c[6:4] == 3'b000) begin
            g = hex_glyph(c[3:0]);
        end else if (c >= 7'h30 && c <= 7'h39) begin
            g = hex_glyph(c[3:0]);
        end else if ((c >= 7'h41 && c <= 7'h46) || (c >= 7'h61 && c <= 7'h66)) begin
            g = hex_glyph(c[3:0] + 4'd9);
        end else if (c == 7'h2D) begin
            g = 7'h3F;
        end else if (c == 7'h5F) begin
            g = 7'h77;
        end
        return g;
    endfunction

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            localparam logic [PW-1:0] BLANK_P = PW'(BLANK_CYCLES);
            assign in_blank = (presc < BLANK_P);
        end else begin : g_noblank
            assign in_blank = 1'b0;
        end
    endgenerate

    assign cur_byte = ssd_bits[{digit, 3'b000} +: 8];

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [3:0] byte_zero;
    logic [3:0] lead_zero;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            byte_zero[i] = (ssd_bits[i*8 +: 8] == 8'h00);
        end
        // Digit 0 is never suppressed, so a lone zero still shows.
        lead_zero[3] = byte_zero[3];
        lead_zero[2] = lead_zero[3] & byte_zero[2];
        lead_zero[1] = lead_zero[2] & byte_zero[1];
        lead_zero[0] = 1'b0;
    end

    assign suppress = ssd_char_mode & lead_zero[digit];
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        an_d  = 4'hF;
        seg_d = 8'hFF;
        if (!in_blank) begin
            an_d = ~(4'b0001 << digit);
            if (suppress) begin
                seg_d = 8'hFF;
            end else if (ssd_char_mode) begin
                seg_d = {~cur_byte[7], char_glyph(cur_byte[6:0])};
            end else begin
                seg_d = cur_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            digit <= 2'd0;
            an    <= 4'hF;
            seg   <= 8'hFF;
        end else begin
            if (presc == PRE_LAST) begin
                presc <= '0;
                digit <= digit + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_ssd_driver.sv
// tb/tb_ssd_driver.sv - self-checking bench for ssd_driver (SCAN_DIV=8, BLANK_CYCLES=2)
module tb_ssd_driver;

    logic        clk;
    logic        rst_n;
    logic [31:0] ssd_bits;
    logic        ssd_char_mode;
    logic [7:0]  seg;
    logic [3:0]  an;

    ssd_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ssd_bits     (ssd_bits),
        .ssd_char_mode(ssd_char_mode),
        .seg          (seg),
        .an           (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bits;
        logic        mode;
        logic [7:0]  s3;
        logic [7:0]  s2;
        logic [7:0]  s1;
        logic [7:0]  s0;
    } vec_t;

    vec_t        vecs [8];
    logic [11:0] sb_q [$];
    logic [7:0]  exp_seg [4];
    int          t;
    int          n_checks;
    int          n_pass;
    int          an_low [4];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got an=%h seg=%h, expected an=%h seg=%h (t=%0d)",
                      name, act[11:8], act[7:0], req[11:8], req[7:0], t);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Expected output for the edge that closes cycle t since reset release.
    task automatic step(input string name);
        int         p;
        int         d;
        logic [3:0] ea;
        logic [7:0] es;
        logic [11:0] got;
        logic [11:0] req;
        p = t % 8;
        d = (t / 8) % 4;
        if (p < 2) begin
            ea = 4'hF;
            es = 8'hFF;
        end else begin
            ea = ~(4'b0001 << d);
            es = exp_seg[d];
        end
        sb_q.push_back({ea, es});
        @(posedge clk);
        t++;
        @(negedge clk);
        got = {an, seg};
        req = sb_q.pop_front();
        for (int i = 0; i < 4; i++) if (!an[i]) an_low[i]++;
        check(name, got, req);
    endtask

    task automatic load(input int k);
        ssd_bits      = vecs[k].bits;
        ssd_char_mode = vecs[k].mode;
        exp_seg[3]    = vecs[k].s3;
        exp_seg[2]    = vecs[k].s2;
        exp_seg[1]    = vecs[k].s1;
        exp_seg[0]    = vecs[k].s0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        t        = 0;

        vecs[0] = '{32'h01020304, 1'b1, 8'hF9, 8'hA4, 8'hB0, 8'h99};
        vecs[1] = '{32'hA55A00FF, 1'b0, 8'hA5, 8'h5A, 8'h00, 8'hFF};
        vecs[2] = '{32'h2DB0207E, 1'b1, 8'hBF, 8'h40, 8'hFF, 8'hFF};
`ifdef SSD_LEADING_ZERO_BLANK_EN
        vecs[3] = '{32'h00000007, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hF8};
`else
        vecs[3] = '{32'h00000007, 1'b1, 8'hC0, 8'hC0, 8'hC0, 8'hF8};
`endif
        vecs[4] = '{32'h41662D5F, 1'b1, 8'h88, 8'h8E, 8'hBF, 8'hF7};
        vecs[5] = '{32'h0A0B0C0D, 1'b1, 8'h88, 8'h83, 8'hC6, 8'hA1};
        vecs[6] = '{32'h39616445, 1'b1, 8'h90, 8'h88, 8'hA1, 8'h86};
        vecs[7] = '{32'h80000000, 1'b1, 8'h40, 8'hC0, 8'hC0, 8'hC0};

        // Reset held for 5 cycles: outputs stay dark throughout.
        rst_n = 1'b0;
        load(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_dark", {an, seg}, 12'hFFF);
        end
        rst_n = 1'b1;
        t = 0;

        // First active digit appears on the third edge after release.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("first_active", {an, seg}, (i == 2) ? 12'hE99 : 12'hFFF);
        end
        t = 3;

        // Table: each vector runs one full 32-cycle scan.
        for (int k = 0; k < 8; k++) begin
            load(k);
            for (int i = 0; i < 4; i++) an_low[i] = 0;
            for (int c = 0; c < 32; c++) step($sformatf("vec%0d", k));
            for (int i = 0; i < 4; i++) check_int($sformatf("an%0d_low_count_vec%0d", i, k), an_low[i], 6);
        end

        // Mode switch mid-period: bits mode takes effect one cycle after the input change.
        load(0);
        while ((t % 32) != 12) step("align");
        ssd_char_mode = 1'b0;
        exp_seg[1] = 8'h03;
        step("mode_switch");
        check_int("mode_switch_seg", int'(seg), 32'h03);

        // Asynchronous reset mid-scan: dark before the next edge, scan restarts at digit 0.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset_dark", {an, seg}, 12'hFFF);
        @(negedge clk);
        check("reset_hold_dark", {an, seg}, 12'hFFF);
        rst_n = 1'b1;
        t = 0;
        load(0);
        for (int c = 0; c < 12; c++) step("post_reset_scan");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
